// File: rtl/ble_spi_frame_streamer.sv
// Latches one encoder frame, streams it byte by byte into SPI_Master under chip
// select, and collects the radio's reply bytes. Reports done, or error on bad length/timeout.
module ble_spi_frame_streamer #(
  parameter int MAX_BYTES       = 18,
  parameter int CS_SETUP_CLKS   = 4,
  parameter int CS_HOLD_CLKS    = 4,
  parameter int INTER_BYTE_CLKS = 0,
  parameter int TIMEOUT         = 2000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [8*MAX_BYTES-1:0] frame_data,
  input  logic [4:0]             frame_len,
  input  logic                   frame_valid,
  output logic [7:0]             spi_tx_byte,
  output logic                   spi_tx_dv,
  input  logic                   spi_tx_ready,
  input  logic                   spi_rx_dv,
  input  logic [7:0]             spi_rx_byte,
  output logic                   spi_cs_n,
  output logic [8*MAX_BYTES-1:0] rx_data,
  output logic [4:0]             rx_count,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  localparam int W     = 8 * MAX_BYTES;
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  localparam logic [4:0]       MAX_LEN    = 5'(MAX_BYTES);
  localparam logic [15:0]      SETUP_LAST = 16'(CS_SETUP_CLKS - 1);
  localparam logic [15:0]      HOLD_LAST  = 16'(CS_HOLD_CLKS - 1);
  localparam logic [15:0]      GAP_LAST   = 16'(INTER_BYTE_CLKS - 1);
  localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, CS_SETUP, SEND, WAIT_RX, GAP, CS_HOLD} state_t;

  state_t           state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [W-1:0]     shift_q, shift_d;
  logic [W-1:0]     rx_data_q, rx_data_d;
  logic [4:0]       len_q, len_d;
  logic [4:0]       byte_idx_q, byte_idx_d;
  logic [4:0]       rx_count_q, rx_count_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic             tx_dv_q, tx_dv_d;
  logic             cs_n_q, cs_n_d;
  logic             done_q, done_d;
  logic             error_q, error_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    len_d      = len_q;
    byte_idx_d = byte_idx_q;
    rx_count_d = rx_count_q;
    tx_byte_d  = tx_byte_q;
    tx_dv_d    = 1'b0;
    cs_n_d     = cs_n_q;
    done_d     = 1'b0;
    error_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (frame_valid) begin
          if (frame_len == 5'd0 || frame_len > MAX_LEN) begin
            error_d = 1'b1;
          end else begin
            shift_d    = frame_data;
            len_d      = frame_len;
            rx_data_d  = '0;
            byte_idx_d = '0;
            cnt_d      = '0;
            cs_n_d     = 1'b0;
            state_d    = (CS_SETUP_CLKS == 0) ? SEND : CS_SETUP;
          end
        end
      end
      CS_SETUP: begin
        if (cnt_q == SETUP_LAST) state_d = SEND;
        else                     cnt_d   = cnt_q + 16'd1;
      end
      SEND: begin
        if (spi_tx_ready) begin
          tx_byte_d = shift_q[W-1 -: 8];
          tx_dv_d   = 1'b1;
          shift_d   = {shift_q[W-9:0], 8'h00};
          tmo_d     = '0;
          state_d   = WAIT_RX;
        end
      end
      WAIT_RX: begin
        // A reply landing on the last timeout cycle still counts.
        if (spi_rx_dv) begin
          rx_data_d  = {rx_data_q[W-9:0], spi_rx_byte};
          byte_idx_d = byte_idx_q + 5'd1;
          cnt_d      = '0;
          if (byte_idx_q + 5'd1 == len_q) begin
            if (CS_HOLD_CLKS == 0) begin
              cs_n_d     = 1'b1;
              rx_count_d = len_q;
              done_d     = 1'b1;
              state_d    = IDLE;
            end else begin
              state_d = CS_HOLD;
            end
          end else begin
            state_d = (INTER_BYTE_CLKS == 0) ? SEND : GAP;
          end
        end else if (tmo_q == TMO_LAST) begin
          error_d = 1'b1;
          cs_n_d  = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) state_d = SEND;
        else                   cnt_d   = cnt_q + 16'd1;
      end
      CS_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cs_n_d     = 1'b1;
          rx_count_d = len_q;
          done_d     = 1'b1;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      tmo_q      <= '0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      len_q      <= '0;
      byte_idx_q <= '0;
      rx_count_q <= '0;
      tx_byte_q  <= '0;
      tx_dv_q    <= 1'b0;
      cs_n_q     <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      len_q      <= len_d;
      byte_idx_q <= byte_idx_d;
      rx_count_q <= rx_count_d;
      tx_byte_q  <= tx_byte_d;
      tx_dv_q    <= tx_dv_d;
      cs_n_q     <= cs_n_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign spi_tx_byte = tx_byte_q;
  assign spi_tx_dv   = tx_dv_q;
  assign spi_cs_n    = cs_n_q;
  assign rx_data     = rx_data_q;
  assign rx_count    = rx_count_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign error       = error_q;

endmodule

// File: tb/tb_ble_spi_frame_streamer.sv
// Bench for ble_spi_frame_streamer: a per-cycle expected timeline derived from the
// frame timing rules, a loopback radio (rx = tx ^ FF, 16 cycles later) and directed scenarios.
module tb_ble_spi_frame_streamer;
  localparam int MAXC  = 8192;
  localparam int SETUP = 4;
  localparam int HOLD  = 4;
  localparam int GAPC  = 0;
  localparam int TMO   = 2000;
  localparam int LAT   = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [143:0] frame_data = '0;
  logic [4:0]   frame_len = '0;
  logic         frame_valid = 1'b0;
  logic [7:0]   spi_tx_byte;
  logic         spi_tx_dv;
  logic         spi_tx_ready = 1'b0;
  logic         spi_rx_dv = 1'b0;
  logic [7:0]   spi_rx_byte = 8'h00;
  logic         spi_cs_n;
  logic [143:0] rx_data;
  logic [4:0]   rx_count;
  logic         busy, done, error;

  ble_spi_frame_streamer #(
    .MAX_BYTES(18), .CS_SETUP_CLKS(SETUP), .CS_HOLD_CLKS(HOLD),
    .INTER_BYTE_CLKS(GAPC), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset), .frame_data(frame_data), .frame_len(frame_len),
    .frame_valid(frame_valid), .spi_tx_byte(spi_tx_byte), .spi_tx_dv(spi_tx_dv),
    .spi_tx_ready(spi_tx_ready), .spi_rx_dv(spi_rx_dv), .spi_rx_byte(spi_rx_byte),
    .spi_cs_n(spi_cs_n), .rx_data(rx_data), .rx_count(rx_count), .busy(busy),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected outputs per cycle index.
  bit           exp_cs_n [MAXC];
  bit           exp_busy [MAXC];
  bit           exp_dv   [MAXC];
  bit           exp_done [MAXC];
  bit           exp_err  [MAXC];
  bit [7:0]     exp_byte [MAXC];
  bit [4:0]     exp_cnt  [MAXC];
  bit [143:0]   exp_rxd  [MAXC];

  int bp_lo = -1;
  int bp_hi = -2;
  function automatic bit ready_at(int c);
    return !(c >= bp_lo && c <= bp_hi);
  endfunction

  // Frame accepted with frame_valid high in cycle f; returns the done/error cycle.
  function automatic int plan_frame(int f, logic [143:0] data, int len, bit answer);
    int t, c, tdv, trx, tend;
    logic [143:0] rxd;
    bit timed_out;
    rxd = '0;
    timed_out = 1'b0;
    t = f + 1 + SETUP;
    trx = t;
    tend = t;
    for (int k = 0; k < len; k++) begin
      c = t;
      while (!ready_at(c)) c++;
      tdv = c + 1;
      exp_dv[tdv] = 1'b1;
      exp_byte[tdv] = data[143-8*k -: 8];
      if (!answer) begin
        tend = tdv + TMO;
        timed_out = 1'b1;
        break;
      end
      trx = tdv + LAT;
      rxd = {rxd[135:0], data[143-8*k -: 8] ^ 8'hFF};
      t = trx + 1 + GAPC;
    end
    if (!timed_out) tend = trx + HOLD + 1;
    for (int i = f + 1; i < tend; i++) begin
      exp_cs_n[i] = 1'b0;
      exp_busy[i] = 1'b1;
    end
    if (timed_out) exp_err[tend] = 1'b1;
    else           exp_done[tend] = 1'b1;
    for (int i = tend; i < MAXC; i++) begin
      exp_rxd[i] = rxd;
      if (!timed_out) exp_cnt[i] = 5'(len);
    end
    return tend;
  endfunction

  function automatic void reset_model(int r);
    for (int i = r; i < MAXC; i++) begin
      exp_cs_n[i] = 1'b1; exp_busy[i] = 1'b0; exp_dv[i] = 1'b0; exp_done[i] = 1'b0;
      exp_err[i] = 1'b0; exp_cnt[i] = '0; exp_rxd[i] = '0;
    end
  endfunction

  int checks = 0;
  int errors = 0;
  task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // Loopback radio and ready stimulus.
  int         pend_cyc = -1;
  logic [7:0] pend_byte = 8'h00;
  bit         resp_en = 1'b1;
  always @(posedge clk) begin
    #1;
    spi_tx_ready = ready_at(cyc);
    if (cyc == pend_cyc) begin
      spi_rx_dv = 1'b1;
      spi_rx_byte = pend_byte;
    end else begin
      spi_rx_dv = 1'b0;
      spi_rx_byte = 8'h00;
    end
  end

  int         dv_seen = 0, done_seen = 0, err_seen = 0, last_err_cyc = -1;
  logic [7:0] txq[$];
  int         dvq[$];

  always @(negedge clk) begin : compare
    int c;
    c = cyc;
    if (c < MAXC) begin
      chk("cs_n", spi_cs_n, exp_cs_n[c]);
      chk("tx_dv", spi_tx_dv, exp_dv[c]);
      if (exp_dv[c]) chk("tx_byte", spi_tx_byte, exp_byte[c]);
      chk("busy", busy, exp_busy[c]);
      chk("done", done, exp_done[c]);
      chk("error", error, exp_err[c]);
      chk("rx_count", rx_count, exp_cnt[c]);
      if (!exp_busy[c]) chk("rx_data", rx_data, exp_rxd[c]);
    end
    if (spi_tx_dv === 1'b1) begin
      dv_seen++;
      txq.push_back(spi_tx_byte);
      dvq.push_back(c);
      if (resp_en) begin
        pend_cyc = c + LAT;
        pend_byte = spi_tx_byte ^ 8'hFF;
      end
    end
    if (done === 1'b1) done_seen++;
    if (error === 1'b1) begin
      err_seen++;
      last_err_cyc = c;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input logic [143:0] d, input logic [4:0] len, input bit answer,
                           output int f, output int tend);
    frame_data = d; frame_len = len; frame_valid = 1'b1;
    f = cyc;
    tend = plan_frame(f, d, int'(len), answer);
    step(1);
    frame_valid = 1'b0;
  endtask

  task automatic bad_frame(input logic [4:0] len, output int f);
    frame_data = {144{1'b1}}; frame_len = len; frame_valid = 1'b1;
    f = cyc;
    exp_err[f + 1] = 1'b1;
    step(1);
    frame_valid = 1'b0;
  endtask

  initial begin
    int f, tend, b_dv, b_done, b_err, n, r;
    logic [143:0] d;
    for (int i = 0; i < MAXC; i++) exp_cs_n[i] = 1'b1;
    #1 reset = 1'b0;
    step(3);
    chk("rst_cs_n", spi_cs_n, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_tx_byte", spi_tx_byte, 8'h00);
    chk("rst_rx_data", rx_data, 144'h0);
    reset = 1'b1;
    step(3);

    // Three-byte loopback frame.
    b_dv = dv_seen; b_done = done_seen;
    d = '0; d[143:120] = 24'hA1B2C3;
    run_frame(d, 5'd3, 1'b1, f, tend);
    step(tend - cyc + 3);
    chk("t1_dv_count", dv_seen - b_dv, 3);
    chk("t1_byte0", txq[b_dv], 8'hA1);
    chk("t1_byte1", txq[b_dv + 1], 8'hB2);
    chk("t1_byte2", txq[b_dv + 2], 8'hC3);
    chk("t1_latency", dvq[b_dv] - f, 6);
    chk("t1_rx_data", rx_data[23:0], 24'h5E4D3C);
    chk("t1_rx_count", rx_count, 5'd3);
    chk("t1_done_count", done_seen - b_done, 1);

    // Full 18-byte frame 00..11.
    b_dv = dv_seen;
    for (int i = 0; i < 18; i++) d[143-8*i -: 8] = 8'(i);
    run_frame(d, 5'd18, 1'b1, f, tend);
    step(tend - cyc + 3);
    chk("t2_dv_count", dv_seen - b_dv, 18);
    chk("t2_rx_count", rx_count, 5'd18);
    chk("t2_rx_first", rx_data[143:136], 8'hFF);
    chk("t2_rx_last", rx_data[7:0], 8'hEE);

    // Length errors.
    b_dv = dv_seen; b_err = err_seen;
    bad_frame(5'd0, f);
    step(3);
    chk("t3_err_cyc0", last_err_cyc, f + 1);
    bad_frame(5'd19, f);
    step(3);
    chk("t3_err_cyc19", last_err_cyc, f + 1);
    chk("t3_err_count", err_seen - b_err, 2);
    chk("t3_dv_count", dv_seen - b_dv, 0);

    // Timeout on the first reply.
    resp_en = 1'b0;
    b_dv = dv_seen; b_done = done_seen;
    d = '0; d[143:128] = 16'h3C5A;
    run_frame(d, 5'd2, 1'b0, f, tend);
    step(tend - cyc + 20);
    chk("t4_dv_count", dv_seen - b_dv, 1);
    chk("t4_err_delay", last_err_cyc - dvq[b_dv], 2000);
    chk("t4_no_done", done_seen - b_done, 0);
    chk("t4_cs_n", spi_cs_n, 1'b1);
    chk("t4_rx_count_kept", rx_count, 5'd18);
    resp_en = 1'b1;

    // Backpressure with an ignored mid-frame frame_valid.
    b_dv = dv_seen; b_done = done_seen;
    bp_lo = cyc + 3; bp_hi = cyc + 52;
    d = '0; d[143:128] = 16'h5566;
    run_frame(d, 5'd2, 1'b1, f, tend);
    step(20);
    frame_data = {144{1'b1}}; frame_len = 5'd5; frame_valid = 1'b1;
    step(1);
    frame_valid = 1'b0;
    step(f + 53 - cyc);
    chk("t5_no_dv_stalled", dv_seen - b_dv, 0);
    step(tend - cyc + 3);
    chk("t5_first_dv", dvq[b_dv] - f, 54);
    chk("t5_dv_count", dv_seen - b_dv, 2);
    chk("t5_rx_data", rx_data[15:0], 16'hAA99);
    chk("t5_rx_count", rx_count, 5'd2);
    chk("t5_done_count", done_seen - b_done, 1);
    bp_lo = -1; bp_hi = -2;

    // Reset during WAIT_RX of byte 2, then a one-byte frame.
    b_dv = dv_seen;
    d = '0; d[143:120] = 24'h112233;
    run_frame(d, 5'd3, 1'b1, f, tend);
    n = 0;
    while (dv_seen < b_dv + 2 && n < 200) begin
      step(1);
      n++;
    end
    chk("t6_second_dv_seen", (n < 200), 1'b1);
    step(3);
    r = cyc;
    reset_model(r);
    pend_cyc = -1;
    reset = 1'b0;
    #1;
    chk("t6_cs_n", spi_cs_n, 1'b1);
    chk("t6_busy", busy, 1'b0);
    chk("t6_tx_dv", spi_tx_dv, 1'b0);
    chk("t6_tx_byte", spi_tx_byte, 8'h00);
    chk("t6_rx_data", rx_data, 144'h0);
    chk("t6_rx_count", rx_count, 5'd0);
    chk("t6_done_err", {done, error}, 2'b00);
    step(2);
    reset = 1'b1;
    step(2);
    b_done = done_seen;
    d = '0; d[143:136] = 8'h7E;
    run_frame(d, 5'd1, 1'b1, f, tend);
    step(tend - cyc + 3);
    chk("t6_new_rx_count", rx_count, 5'd1);
    chk("t6_new_rx_data", rx_data, 144'h81);
    chk("t6_new_done", done_seen - b_done, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
